div_radix2: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage of the five-stage MIPS32 core. It consumes the `div_valid`/`signed_div` pair produced by instruction decode for DIV/DIVU, holds the pipeline via `stall_div` while iterating, and returns `{remainder, quotient}` for the HI/LO write. It uses radix-2 restoring division on operand magnitudes, one quotient bit per cycle, and fixed latency.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_radix2_if.sv | 29 ++
 rtl/div_radix2.sv | 128 ++++++++++++
 tb/tb_div_radix2.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the radix-2 restoring divider.
//   div_state_t   : divider FSM state encoding
//   DIV_ITERS     : number of quotient bits produced (one per BUSY cycle)
//   DIV_BY_ZERO_Q : quotient returned for any divide by zero
// ---------------------------------------------------------------------------
package div_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   localparam int          DIV_ITERS     = 32;
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_radix2_if.sv
// ---------------------------------------------------------------------------
// div_radix2_if
// Request/response bundle between the execute stage (master) and the
// divider (slave).
//   valid, signed_div, a, b, annul : master -> divider
//   stall_div, ready, result       : divider -> master
// ---------------------------------------------------------------------------
interface div_radix2_if #(
   parameter int WIDTH = 32
);
   logic                 valid;
   logic                 signed_div;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 annul;
   logic                 stall_div;
   logic                 ready;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output valid, signed_div, a, b, annul,
      input  stall_div, ready, result
   );

   modport slave (
      input  valid, signed_div, a, b, annul,
      output stall_div, ready, result
   );
endinterface

// File: rtl/div_radix2.sv
// ---------------------------------------------------------------------------
// div_radix2
// Multi-cycle DIV/DIVU unit for the MIPS32 execute stage. Restoring radix-2
// division on operand magnitudes, one quotient bit per cycle, fixed latency
// of DIV_ITERS+1 cycles from acceptance to ready (1 cycle for divide by 0).
// Ports:
//   clk    : core clock, rising edge
//   resetn : asynchronous active-low reset
//   io     : div_radix2_if.slave
//            valid/signed_div/a/b sampled in IDLE, annul cancels in flight,
//            stall_div holds the pipeline, ready pulses with
//            result = {remainder (HI), quotient (LO)}
// WIDTH must equal DIV_ITERS.
// ---------------------------------------------------------------------------
module div_radix2
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         resetn,
   div_radix2_if.slave  io
);

   localparam int CW = $clog2(DIV_ITERS);

   // Two's-complement magnitude, only for signed operands with sign bit set.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                            input logic             sgn);
      return (sgn && x[WIDTH-1]) ? -x : x;
   endfunction

   div_state_t           state_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     quo_q;
   logic [WIDTH-1:0]     bmag_q;
   logic                 neg_q_q;
   logic                 neg_r_q;
   logic                 ready_q;
   logic [2*WIDTH-1:0]   result_q;

   logic                 accept;
   logic [WIDTH:0]       rem_sh;
   logic                 ge;
   logic [WIDTH-1:0]     rem_d;
   logic [WIDTH-1:0]     quo_d;

   assign accept = (state_q == IDLE) && io.valid && !io.annul;

   // One restoring step on {rem, quo}. The partial remainder is always
   // below |b|, so it fits in WIDTH bits; only the shifted value needs the
   // extra bit, and only for the compare. The low WIDTH bits of the
   // subtraction are exact whenever the compare succeeds.
   always_comb begin
      rem_sh = {rem_q, quo_q[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, bmag_q});
      rem_d  = ge ? (rem_sh[WIDTH-1:0] - bmag_q) : rem_sh[WIDTH-1:0];
      quo_d  = {quo_q[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         bmag_q   <= '0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (accept) begin
                  neg_q_q <= io.signed_div & (io.a[WIDTH-1] ^ io.b[WIDTH-1]);
                  neg_r_q <= io.signed_div & io.a[WIDTH-1];
                  rem_q   <= '0;
                  quo_q   <= mag(io.a, io.signed_div);
                  bmag_q  <= mag(io.b, io.signed_div);
                  cnt_q   <= '0;
                  if (io.b == '0) begin
                     result_q <= {io.a, DIV_BY_ZERO_Q};
                     ready_q  <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (io.annul) begin
                  state_q <= IDLE;
               end else begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CW'(DIV_ITERS - 1)) begin
                     // Sign fix-up folded into the last iteration so the
                     // result register is ready together with the pulse.
                     result_q <= {neg_r_q ? -rem_d : rem_d,
                                  neg_q_q ? -quo_d : quo_d};
                     ready_q  <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               // ready was registered on entry; an annul here only matters
               // for the transition, which is back to IDLE regardless.
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign io.stall_div = accept || (state_q == BUSY);
   assign io.ready     = ready_q;
   assign io.result    = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// ---------------------------------------------------------------------------
// tb_div_radix2
// Directed bench for div_radix2: reset state, unsigned/signed quotients,
// signed overflow, divide by zero, annul, annul+valid in IDLE, back-to-back
// requests with valid held through BUSY, and asynchronous reset mid-divide.
// Cycle 0 is the cycle in which valid is presented in IDLE.
// ---------------------------------------------------------------------------
module tb_div_radix2;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   always #5 clk = ~clk;

   div_radix2_if #(.WIDTH(32)) dif ();

   div_radix2 #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .io     (dif.slave)
   );

   int n_run  = 0;
   int n_fail = 0;

   // Issue one divide and follow it until ready (bounded). Returns the cycle
   // ready was seen (-1 on timeout), the number of cycles stall_div was high
   // and the result sampled with ready. Ends in the ready cycle.
   task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                          input logic sgn, output int rdy_cyc,
                          output int stalls, output logic [63:0] res);
      @(posedge clk);
      @(negedge clk);
      dif.valid = 1'b1; dif.signed_div = sgn; dif.a = av; dif.b = bv;
      #1;
      stalls  = dif.stall_div ? 1 : 0;
      rdy_cyc = -1;
      res     = 'x;
      @(posedge clk); #1;
      dif.valid = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         if (dif.stall_div) stalls++;
         if (dif.ready) begin
            rdy_cyc = c;
            res     = dif.result;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      #1 resetn = 1'b0;
      #3;
      n_run++; if (dif.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", dif.ready); end
      n_run++; if (dif.result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", dif.result); end
      n_run++; if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", dif.stall_div); end
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
   endtask

   task automatic test_divu_basic;
      int rc, st; logic [63:0] r;
      run_div(32'd100, 32'd7, 1'b0, rc, st, r);
      n_run++; if (rc !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d expected 33", rc); end
      n_run++; if (st !== 33) begin n_fail++; $display("FAIL divu_stall_cycles: got %0d expected 33", st); end
      n_run++; if (r[31:0] !== 32'd14) begin n_fail++; $display("FAIL divu_quot: got %h expected %h", r[31:0], 32'd14); end
      n_run++; if (r[63:32] !== 32'd2) begin n_fail++; $display("FAIL divu_rem: got %h expected %h", r[63:32], 32'd2); end
      @(posedge clk); #1;
      n_run++; if (dif.ready !== 1'b0) begin n_fail++; $display("FAIL divu_ready_pulse: got %b expected 0", dif.ready); end
      n_run++; if (dif.result !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_result_hold: got %h expected %h", dif.result, {32'd2, 32'd14}); end
   endtask

   task automatic test_signed;
      int rc, st; logic [63:0] r;
      run_div(32'hFFFF_FFF9, 32'd2, 1'b1, rc, st, r);
      n_run++; if (rc !== 33) begin n_fail++; $display("FAIL div_neg_latency: got %0d expected 33", rc); end
      n_run++; if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL div_neg_result: got %h expected %h", r, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
   endtask

   task automatic test_overflow;
      int rc, st; logic [63:0] r;
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, rc, st, r);
      n_run++; if (r !== {32'h0, 32'h8000_0000}) begin n_fail++; $display("FAIL div_overflow: got %h expected %h", r, {32'h0, 32'h8000_0000}); end
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rc, st, r);
      n_run++; if (r !== {32'h8000_0000, 32'h0}) begin n_fail++; $display("FAIL divu_big: got %h expected %h", r, {32'h8000_0000, 32'h0}); end
   endtask

   task automatic test_div_zero;
      int rc, st; logic [63:0] r;
      run_div(32'h0000_1234, 32'h0, 1'b0, rc, st, r);
      n_run++; if (rc !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", rc); end
      n_run++; if (st !== 1) begin n_fail++; $display("FAIL dz_stall_cycles: got %0d expected 1", st); end
      n_run++; if (r !== {32'h0000_1234, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL dz_unsigned: got %h expected %h", r, {32'h0000_1234, 32'hFFFF_FFFF}); end
      run_div(32'hFFFF_FFFB, 32'h0, 1'b1, rc, st, r);
      n_run++; if (r !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL dz_signed: got %h expected %h", r, {32'hFFFF_FFFB, 32'hFFFF_FFFF}); end
   endtask

   task automatic test_annul;
      int rc, st; logic [63:0] r;
      logic seen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      dif.valid = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd50; dif.b = 32'd5;
      @(posedge clk); #1;
      dif.valid = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (dif.ready) seen = 1'b1;
         @(posedge clk); #1;
      end
      dif.annul = 1'b1;                 // cycle 10
      @(posedge clk); #1;
      dif.annul = 1'b0;                 // cycle 11
      n_run++; if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL annul_idle: got stall %b expected 0", dif.stall_div); end
      for (int c = 11; c < 50; c++) begin
         if (dif.ready) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL annul_no_ready: got %b expected 0", seen); end
      n_run++; if (dif.result !== {32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL annul_result_hold: got %h expected %h", dif.result, {32'hFFFF_FFFB, 32'hFFFF_FFFF}); end
      run_div(32'd9, 32'd3, 1'b0, rc, st, r);
      n_run++; if (rc !== 33) begin n_fail++; $display("FAIL post_annul_latency: got %0d expected 33", rc); end
      n_run++; if (r !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL post_annul_result: got %h expected %h", r, {32'd0, 32'd3}); end
   endtask

   task automatic test_annul_valid_idle;
      logic seen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      dif.valid = 1'b1; dif.annul = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd8; dif.b = 32'd2;
      #1;
      n_run++; if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL annul_valid_stall: got %b expected 0", dif.stall_div); end
      @(posedge clk); #1;
      dif.valid = 1'b0; dif.annul = 1'b0;
      for (int c = 1; c < 40; c++) begin
         if (dif.ready || dif.stall_div) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL annul_valid_accepted: got %b expected 0", seen); end
      n_run++; if (dif.result !== {32'd0, 32'd3}) begin n_fail++; $display("FAIL annul_valid_result: got %h expected %h", dif.result, {32'd0, 32'd3}); end
   endtask

   task automatic test_back_to_back;
      int r1c = -1, r2c = -1;
      logic [63:0] r1 = 'x, r2 = 'x;
      logic st33 = 1'bx, st34 = 1'bx;
      @(posedge clk);
      @(negedge clk);
      dif.valid = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd20; dif.b = 32'd4;
      @(posedge clk); #1;
      dif.a = 32'd81; dif.b = 32'd9;    // valid stays high through BUSY/DONE
      for (int c = 1; c <= 80; c++) begin
         if (c == 33) st33 = dif.stall_div;
         if (c == 34) st34 = dif.stall_div;
         if (c == 35) dif.valid = 1'b0;
         if (dif.ready) begin
            if (r1c < 0) begin r1c = c; r1 = dif.result; end
            else if (r2c < 0) begin r2c = c; r2 = dif.result; end
         end
         @(posedge clk); #1;
      end
      n_run++; if (r1c !== 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 33", r1c); end
      n_run++; if (r1 !== {32'd0, 32'd5}) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", r1, {32'd0, 32'd5}); end
      n_run++; if (st33 !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_done: got %b expected 0", st33); end
      n_run++; if (st34 !== 1'b1) begin n_fail++; $display("FAIL b2b_stall_accept: got %b expected 1", st34); end
      n_run++; if (r2c !== 67) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 67", r2c); end
      n_run++; if (r2 !== {32'd0, 32'd9}) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", r2, {32'd0, 32'd9}); end
   endtask

   task automatic test_reset_mid;
      logic seen = 1'b0;
      @(posedge clk);
      @(negedge clk);
      dif.valid = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd100; dif.b = 32'd7;
      @(posedge clk); #1;
      dif.valid = 1'b0;
      for (int c = 1; c < 20; c++) begin
         @(posedge clk); #1;
      end
      n_run++; if (dif.stall_div !== 1'b1) begin n_fail++; $display("FAIL mid_busy_stall: got %b expected 1", dif.stall_div); end
      resetn = 1'b0;                    // cycle 20
      #1;
      n_run++; if (dif.ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 0", dif.ready); end
      n_run++; if (dif.result !== 64'h0) begin n_fail++; $display("FAIL mid_reset_result: got %h expected 0", dif.result); end
      n_run++; if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stall: got %b expected 0", dif.stall_div); end
      @(negedge clk) resetn = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (dif.ready || dif.stall_div) seen = 1'b1;
      end
      n_run++; if (seen !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", seen); end
   endtask

   initial begin
      dif.valid = 1'b0; dif.signed_div = 1'b0; dif.annul = 1'b0;
      dif.a = '0; dif.b = '0;
      test_reset();
      test_divu_basic();
      test_signed();
      test_overflow();
      test_div_zero();
      test_annul();
      test_annul_valid_idle();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
